// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, baud divisor helper
// and the data-bit count of one character.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Single-character UART receiver: rxd synchroniser, baud counter and byte FSM.
// Define UART_RX_PARITY_EN for 8E1 framing; otherwise 8N1.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       byte_err_o,
  output logic       start_edge_o,
  output logic       idle_o,
  output logic [2:0] state_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [1:0]    sync_q;
  logic [1:0]    fill_q;
  logic          prev_q;
  logic          armed_q;
  logic          rxd_s;
  logic          start_edge;

  assign rxd_s = sync_q[1];

  // After reset the line must be seen high with real synchronised data
  // before a falling edge may start a character.
  assign start_edge = armed_q & prev_q & ~rxd_s & (state_q == IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      fill_q  <= 2'b00;
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      sync_q  <= {sync_q[0], rxd_i};
      fill_q  <= {fill_q[0], 1'b1};
      prev_q  <= rxd_s;
      armed_q <= armed_q | (fill_q[1] & rxd_s);
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    bit_d        = bit_q;
    sh_d         = sh_q;
    byte_valid_o = 1'b0;
    byte_err_o   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_edge) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A start bit that is high again at mid-bit was only a glitch.
          state_d = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {rxd_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxd_s != ^sh_q) begin
            byte_err_o = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = STOP;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        // Accept at mid stop bit so a back-to-back start edge is not missed.
        if (cnt_q == FULL_M1) begin
          state_d = IDLE;
          if (rxd_s) byte_valid_o = 1'b1;
          else       byte_err_o   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_data_o  = sh_q;
  assign start_edge_o = start_edge;
  assign idle_o       = (state_q == IDLE);
  assign state_o      = state_q;

endmodule

// File: rtl/uart_rx_frame64.sv
// Assembles BYTES received UART characters into one 64-bit word with a done
// strobe; reports stop/parity/inter-byte timeout errors. Parity: UART_RX_PARITY_EN.
module uart_rx_frame64
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int BYTES        = 8,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [63:0] data_out_64,
  output logic        data_out_done,
  output logic        frame_err
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BCW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [31:0]  TO_M1   = 32'(TIMEOUT_BITS * CPB - 1);
  localparam logic [BCW-1:0] LAST_B = BCW'(BYTES - 1);

  logic           byte_valid, byte_err, start_edge, rx_idle;
  logic [7:0]     byte_data;
  logic [2:0]     rx_state;

  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [63:0]    word_q, word_d;
  logic [63:0]    data_q, data_d;
  logic [31:0]    idle_cnt_q, idle_cnt_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_rx_byte (
    .clk_i        (clk),
    .rst_i        (rst),
    .rxd_i        (rxd),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .byte_err_o   (byte_err),
    .start_edge_o (start_edge),
    .idle_o       (rx_idle),
    .state_o      (rx_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
      data_q     <= '0;
      idle_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      data_q     <= data_d;
      idle_cnt_q <= idle_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    data_d     = data_q;
    idle_cnt_d = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    // A start edge beats a timeout landing in the same cycle.
    if (!start_edge && rx_idle && byte_cnt_q != '0) begin
      if (idle_cnt_q == TO_M1) begin
        err_d      = 1'b1;
        byte_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 32'd1;
      end
    end
    if (byte_err) begin
      err_d      = 1'b1;
      byte_cnt_d = '0;
    end else if (byte_valid) begin
      word_d = {word_q[55:0], byte_data};
      if (byte_cnt_q == LAST_B) begin
        data_d     = word_d;
        done_d     = 1'b1;
        byte_cnt_d = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + BCW'(1);
      end
    end
  end

  assign data_out_64   = data_q;
  assign data_out_done = done_q;
  assign frame_err     = err_q;

endmodule
